// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to 32-bit word instruction memory loader
// Optional checksum check enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
`ifdef IMEM_LOADER_CKSUM_EN
    input  logic [31:0]       cksum_exp,
    output logic              cksum_err,
`endif
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);

    state_t              state;
    logic [1:0]          lane;
    logic [23:0]         asm_bytes;
    logic [ADDR_W-1:0]   word_idx;
    logic [ADDR_W:0]     len;
    logic                stall;
    logic [ADDR_W:0]     next_idx;
    logic [ADDR_W:0]     start_len;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0]         sum;
    logic [31:0]         exp_sum;
`endif

    assign next_idx   = (ADDR_W+1)'(word_idx) + (ADDR_W+1)'(1);
    assign start_len  = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign busy       = stall;
    assign core_stall = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lane       <= '0;
            asm_bytes  <= '0;
            word_idx   <= '0;
            len        <= '0;
            stall      <= 1'b0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum        <= '0;
            exp_sum    <= '0;
            cksum_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        len        <= start_len;
                        word_idx   <= '0;
                        lane       <= '0;
                        asm_bytes  <= '0;
                        word_count <= '0;
                        stall      <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum        <= '0;
                        exp_sum    <= cksum_exp;
                        cksum_err  <= 1'b0;
`endif
                        if (start_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RECV;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_bytes[7:0]   <= byte_data;
                            2'd1: asm_bytes[15:8]  <= byte_data;
                            2'd2: asm_bytes[23:16] <= byte_data;
                            default: begin
                                // Final lane goes straight to the write port.
                                state      <= WRITE;
                                byte_ready <= 1'b0;
                                mem_we     <= 1'b1;
                                mem_waddr  <= 32'(word_idx) << 2;
                                mem_wdata  <= {byte_data, asm_bytes};
                                word_count <= word_count + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CKSUM_EN
                                sum        <= sum + {byte_data, asm_bytes};
`endif
                            end
                        endcase
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    lane   <= '0;
                    if (next_idx == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        word_idx   <= word_idx + ADDR_W'(1);
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    stall <= 1'b0;
                    state <= IDLE;
`ifdef IMEM_LOADER_CKSUM_EN
                    cksum_err <= (sum != exp_sum);
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [8:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, core_stall, busy, done;
    logic [31:0] mem_waddr, mem_wdata;
    logic [8:0]  word_count;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0] cksum_exp = '0;
    logic        cksum_err;
`endif

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_addr = '0;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data),
`ifdef IMEM_LOADER_CKSUM_EN
        .cksum_exp(cksum_exp), .cksum_err(cksum_err),
`endif
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .core_stall(core_stall), .busy(busy),
        .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("waddr", mem_waddr, e[63:32]);
                check("wdata", mem_wdata, e[31:0]);
            end
            check("ready_in_write", 32'(byte_ready), 32'd0);
            last_addr = mem_waddr;
        end
        if (rst_n && done)
            check("stall_at_done", 32'(core_stall), 32'd1);
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            @(negedge clk);
            if (byte_ready) begin @(posedge clk); #1; break; end
            n++;
            if (n > 100) begin check("byte_timeout", 32'd1, 32'd0); break; end
        end
        byte_valid = 1'b0;
    endtask

    task automatic start_load(input int len);
        load_len   = 9'(len);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        int n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 100) begin check("done_timeout", 32'd1, 32'd0); return; end
        end
        check("word_count", 32'(word_count), 32'(exp_count));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("stall_after_done", 32'(core_stall), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    // Reference model: word i is bytes 4i..4i+3 little-endian at byte address 4i.
    task automatic run_load(input int len, input logic [7:0] bytes[$], input bit gaps);
        int eff;
        eff = (len > 256) ? 256 : len;
        for (int i = 0; i < eff; i++) begin
            logic [31:0] w;
            w = 32'(bytes[4*i]) + (32'(bytes[4*i+1]) * 256) +
                (32'(bytes[4*i+2]) * 65536) + (32'(bytes[4*i+3]) * 16777216);
            exp_q.push_back({32'(i * 4), w});
        end
        start_load(len);
        check("stall_in_load", 32'(core_stall), 32'd1);
        for (int i = 0; i < 4 * eff; i++) send_byte(bytes[i], gaps);
        wait_done(eff);
    endtask

    logic [7:0] prog[$];
    logic [7:0] rnd[$];

    initial begin
        prog = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h07};
        #12;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_load(2, prog, 1'b0);
        run_load(2, prog, 1'b1);

        // Zero-length load: done on the very next cycle, no writes.
        start_load(0);
        check("len0_done", 32'(done), 32'd1);
        wait_done(0);

        // A second load_start mid-load must not change the length.
        exp_q.push_back({32'h0, 32'h00000513});
        exp_q.push_back({32'h4, 32'h07B00593});
        start_load(2);
        send_byte(prog[0], 1'b1);
        send_byte(prog[1], 1'b1);
        start_load(1);
        for (int i = 2; i < 8; i++) send_byte(prog[i], 1'b1);
        wait_done(2);

        // Reset mid-word discards the partial word.
        start_load(1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(core_stall), 32'd0);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_count", 32'(word_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        rnd = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load(1, rnd, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, 6);
            rnd.delete();
            for (int i = 0; i < 4 * len; i++) rnd.push_back(8'($urandom));
            run_load(len, rnd, 1'b1);
        end

        rnd.delete();
        for (int i = 0; i < 1024; i++) rnd.push_back(8'($urandom));
        run_load(256, rnd, 1'b0);
        check("last_addr_256", last_addr, 32'h3FC);
        last_addr = '0;
        run_load(300, rnd, 1'b0);
        check("last_addr_clamp", last_addr, 32'h3FC);

`ifdef IMEM_LOADER_CKSUM_EN
        cksum_exp = 32'h07B00AA6;
        run_load(2, prog, 1'b0);
        check("cksum_ok", 32'(cksum_err), 32'd0);
        cksum_exp = 32'h0;
        run_load(2, prog, 1'b0);
        check("cksum_bad", 32'(cksum_err), 32'd1);
        cksum_exp = 32'h07B00AA6;
        exp_q.push_back({32'h0, 32'h00000513});
        exp_q.push_back({32'h4, 32'h07B00593});
        start_load(2);
        check("cksum_cleared", 32'(cksum_err), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0);
        wait_done(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
